// File: rtl/mc_unit_scheduler_pkg.sv
// Shared types for the multi-cycle EX unit scheduler: FSM states and writeback-source encodings.
package mc_unit_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } mcs_state_t;

    typedef logic [2:0] wb_src_t;

    localparam wb_src_t SEL_ALU  = 3'd0;
    localparam wb_src_t SEL_MEM  = 3'd1;
    localparam wb_src_t SEL_PC4  = 3'd2;
    localparam wb_src_t SEL_MUL  = 3'd3;
    localparam wb_src_t SEL_DIV  = 3'd4;
    localparam wb_src_t SEL_FPU  = 3'd5;
    localparam wb_src_t SEL_CSR  = 3'd6;
    localparam wb_src_t SEL_NONE = 3'd7;

    function automatic logic is_mc_src(wb_src_t src);
        return (src == SEL_MUL) || (src == SEL_DIV) || (src == SEL_FPU);
    endfunction

endpackage

// File: rtl/mc_unit_scheduler_if.sv
// Pipeline-side and unit-side handshake bundle of the multi-cycle scheduler.
interface mc_unit_scheduler_if
    import mc_unit_scheduler_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic             valid_in;
    wb_src_t          wb_src_ID;
    logic             ready_in;
    logic             hazard;
    logic             flush;
    logic             valid_in_MUL;
    logic             valid_in_DIV;
    logic             valid_in_FPU;
    logic             ready_out_MUL;
    logic             ready_out_DIV;
    logic             ready_out_FPU;
    logic             valid_out_MUL;
    logic             valid_out_DIV;
    logic             valid_out_FPU;
    logic             unit_ready_in;
    logic             mc_stall;
    logic             busy;
    logic [CNT_W-1:0] stall_cycles;
    logic             cnt_clr;
    logic             timeout_err;

    modport master (
        input  valid_in, wb_src_ID, ready_in, hazard, flush,
        input  ready_out_MUL, ready_out_DIV, ready_out_FPU,
        input  valid_out_MUL, valid_out_DIV, valid_out_FPU,
        input  cnt_clr,
        output valid_in_MUL, valid_in_DIV, valid_in_FPU,
        output unit_ready_in, mc_stall, busy, stall_cycles, timeout_err
    );

    modport slave (
        output valid_in, wb_src_ID, ready_in, hazard, flush,
        output ready_out_MUL, ready_out_DIV, ready_out_FPU,
        output valid_out_MUL, valid_out_DIV, valid_out_FPU,
        output cnt_clr,
        input  valid_in_MUL, valid_in_DIV, valid_in_FPU,
        input  unit_ready_in, mc_stall, busy, stall_cycles, timeout_err
    );

endinterface

// File: rtl/mc_unit_scheduler_sat_counter.sv
// Up-counter that holds at MAX; clear takes priority over increment.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mc_unit_scheduler.sv
// Issues one start handshake per multi-cycle instruction, holds EX until the tagged unit's
// result is consumed, drains results of flushed ops, and keeps stall/watchdog statistics.
//
//   state | meaning
//   IDLE  | no op in flight; request issued combinationally to the selected unit
//   BUSY  | op accepted by unit 'tag'; waiting for its result to be consumed
//   DRAIN | op was flushed; unit_ready_in held high until the stale result is discarded
module mc_unit_scheduler
    import mc_unit_scheduler_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset,
    mc_unit_scheduler_if.master bus
);

    localparam int             TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    mcs_state_t       state;
    wb_src_t          tag;
    logic             timeout_err_q;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] stall_cnt;

    logic is_mc, issue_ok, req_mul, req_div, req_fpu, hs;
    logic done, active, unit_ready, stall;
    logic tmr_clr, tmr_inc, err_set;

    always_comb begin
        is_mc    = bus.valid_in && is_mc_src(bus.wb_src_ID);
        issue_ok = (state == IDLE) && is_mc && !bus.flush;
        req_mul  = issue_ok && (bus.wb_src_ID == SEL_MUL);
        req_div  = issue_ok && (bus.wb_src_ID == SEL_DIV);
        req_fpu  = issue_ok && (bus.wb_src_ID == SEL_FPU);
        hs       = (req_mul && bus.ready_out_MUL) || (req_div && bus.ready_out_DIV) ||
                   (req_fpu && bus.ready_out_FPU);

        // Once issued, only the tagged unit's result is meaningful.
        case (tag)
            SEL_MUL: done = bus.valid_out_MUL;
            SEL_DIV: done = bus.valid_out_DIV;
            SEL_FPU: done = bus.valid_out_FPU;
            default: done = 1'b0;
        endcase

        active     = (state != IDLE);
        unit_ready = 1'b0;
        stall      = is_mc;
        case (state)
            IDLE: begin
                unit_ready = 1'b0;
                stall      = is_mc;
            end
            BUSY: begin
                unit_ready = (bus.ready_in && !bus.hazard) || (bus.flush && done);
                stall      = is_mc && !done;
            end
            DRAIN: begin
                unit_ready = 1'b1;
                stall      = is_mc;
            end
            default: begin
                unit_ready = 1'b0;
                stall      = 1'b0;
            end
        endcase

        // Timer restarts on every entry into BUSY or DRAIN.
        tmr_clr = hs || ((state == BUSY) && bus.flush && !done);
        tmr_inc = active && !done;
        err_set = active && ((timer == TMR_MAX) ||
                             (tmr_inc && (timer == TMR_MAX - TMR_W'(1))));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tag           <= SEL_NONE;
            timeout_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        state <= BUSY;
                        tag   <= bus.wb_src_ID;
                    end
                end
                BUSY: begin
                    if (done && unit_ready) begin
                        state <= IDLE;
                    end else if (bus.flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.cnt_clr) begin
                timeout_err_q <= 1'b0;
            end else if (err_set) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    sat_counter #(.W(TMR_W), .MAX(TMR_MAX)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .cnt   (timer)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.cnt_clr),
        .inc   (stall),
        .cnt   (stall_cnt)
    );

    assign bus.valid_in_MUL  = req_mul;
    assign bus.valid_in_DIV  = req_div;
    assign bus.valid_in_FPU  = req_fpu;
    assign bus.unit_ready_in = unit_ready;
    assign bus.mc_stall      = stall;
    assign bus.busy          = active;
    assign bus.stall_cycles  = stall_cnt;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_mc_unit_scheduler.sv
// Directed bench for mc_unit_scheduler: issue, backpressure, blocked consume, flush/drain, watchdog, reset.
module tb_mc_unit_scheduler;
    import mc_unit_scheduler_pkg::*;

    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mc_unit_scheduler_if #(.CNT_W(CNT_W)) bus ();

    mc_unit_scheduler #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // req is {valid_in_MUL, valid_in_DIV, valid_in_FPU}
    task automatic chk_out(input string tag, input logic [2:0] req, input logic ur,
                           input logic st, input logic bz);
        chk({tag, ".req"}, {29'd0, bus.valid_in_MUL, bus.valid_in_DIV, bus.valid_in_FPU}, {29'd0, req});
        chk({tag, ".unit_ready_in"}, {31'd0, bus.unit_ready_in}, {31'd0, ur});
        chk({tag, ".mc_stall"}, {31'd0, bus.mc_stall}, {31'd0, st});
        chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, bz});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.valid_in      = 1'b0;
        bus.wb_src_ID     = SEL_ALU;
        bus.ready_in      = 1'b0;
        bus.hazard        = 1'b0;
        bus.flush         = 1'b0;
        bus.ready_out_MUL = 1'b0;
        bus.ready_out_DIV = 1'b0;
        bus.ready_out_FPU = 1'b0;
        bus.valid_out_MUL = 1'b0;
        bus.valid_out_DIV = 1'b0;
        bus.valid_out_FPU = 1'b0;
        bus.cnt_clr       = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk_out("reset", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("reset.stall_cycles", 32'(bus.stall_cycles), 32'd0);
        chk("reset.timeout_err", {31'd0, bus.timeout_err}, 32'd0);

        // MUL: one request cycle, result in the 5th BUSY cycle
        tick();
        bus.valid_in = 1'b1; bus.wb_src_ID = SEL_MUL; bus.ready_out_MUL = 1'b1; bus.ready_in = 1'b1;
        settle(); chk_out("mul_issue", 3'b100, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            settle(); chk_out("mul_wait", 3'b000, 1'b1, 1'b1, 1'b1);
            tick();
        end
        bus.valid_out_MUL = 1'b1;
        settle(); chk_out("mul_done", 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        clear_inputs();
        settle(); chk_out("mul_idle", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("mul.stall_cycles", 32'(bus.stall_cycles), 32'd5);

        // DIV with 3 cycles of issue backpressure
        tick();
        bus.valid_in = 1'b1; bus.wb_src_ID = SEL_DIV; bus.ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle(); chk_out("div_bp", 3'b010, 1'b0, 1'b1, 1'b0);
            tick();
        end
        bus.ready_out_DIV = 1'b1;
        settle(); chk_out("div_hs", 3'b010, 1'b0, 1'b1, 1'b0);
        tick();
        bus.valid_out_DIV = 1'b1;
        settle(); chk_out("div_done", 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        clear_inputs();
        settle(); chk_out("div_idle", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("div.stall_cycles", 32'(bus.stall_cycles), 32'd9);

        // FPU result blocked by hazard; foreign valid_out ignored
        tick();
        bus.valid_in = 1'b1; bus.wb_src_ID = SEL_FPU; bus.ready_out_FPU = 1'b1; bus.ready_in = 1'b1;
        settle(); chk_out("fpu_issue", 3'b001, 1'b0, 1'b1, 1'b0);
        tick();
        bus.ready_out_FPU = 1'b0; bus.valid_out_MUL = 1'b1;
        settle(); chk_out("fpu_foreign", 3'b000, 1'b1, 1'b1, 1'b1);
        tick();
        bus.valid_out_MUL = 1'b0; bus.valid_out_FPU = 1'b1; bus.hazard = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle(); chk_out("fpu_hazard", 3'b000, 1'b0, 1'b0, 1'b1);
            tick();
        end
        bus.hazard = 1'b0;
        settle(); chk_out("fpu_consume", 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        clear_inputs();
        settle(); chk_out("fpu_idle", 3'b000, 1'b0, 1'b0, 1'b0);

        // DIV flushed at BUSY cycle 2, result at cycle 10; queued MUL waits for IDLE
        tick();
        bus.valid_in = 1'b1; bus.wb_src_ID = SEL_DIV; bus.ready_out_DIV = 1'b1; bus.ready_in = 1'b1;
        settle(); chk_out("div2_issue", 3'b010, 1'b0, 1'b1, 1'b0);
        tick();
        bus.ready_out_DIV = 1'b0;
        settle(); chk_out("div2_busy", 3'b000, 1'b1, 1'b1, 1'b1);
        tick();
        bus.flush = 1'b1; bus.ready_in = 1'b0;
        settle(); chk_out("div2_flush", 3'b000, 1'b0, 1'b1, 1'b1);
        tick();
        bus.flush = 1'b0; bus.wb_src_ID = SEL_MUL; bus.ready_out_MUL = 1'b1; bus.ready_in = 1'b1;
        for (int c = 3; c <= 9; c++) begin
            bus.flush         = (c == 5);
            bus.valid_out_MUL = (c == 6);
            settle(); chk_out("drain", 3'b000, 1'b1, 1'b1, 1'b1);
            tick();
        end
        bus.flush = 1'b0; bus.valid_out_MUL = 1'b0; bus.valid_out_DIV = 1'b1;
        settle(); chk_out("drain_done", 3'b000, 1'b1, 1'b1, 1'b1);
        tick();
        bus.valid_out_DIV = 1'b0;
        settle(); chk_out("mul2_issue", 3'b100, 1'b0, 1'b1, 1'b0);
        tick();
        bus.valid_out_MUL = 1'b1;
        settle(); chk_out("mul2_done", 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        clear_inputs();
        settle(); chk_out("mul2_idle", 3'b000, 1'b0, 1'b0, 1'b0);

        // Flush blocks issue in IDLE; flush coincident with done skips DRAIN
        tick();
        bus.valid_in = 1'b1; bus.wb_src_ID = SEL_MUL; bus.ready_out_MUL = 1'b1; bus.flush = 1'b1;
        settle(); chk_out("flush_idle", 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        bus.flush = 1'b0;
        settle(); chk_out("mul3_issue", 3'b100, 1'b0, 1'b1, 1'b0);
        tick();
        bus.ready_out_MUL = 1'b0; bus.ready_in = 1'b0; bus.flush = 1'b1; bus.valid_out_MUL = 1'b1;
        settle(); chk_out("flush_done", 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        clear_inputs();
        settle(); chk_out("flush_done_idle", 3'b000, 1'b0, 1'b0, 1'b0);

        // Watchdog: FPU never returns
        tick();
        bus.valid_in = 1'b1; bus.wb_src_ID = SEL_FPU; bus.ready_out_FPU = 1'b1; bus.ready_in = 1'b1;
        settle(); chk_out("wd_issue", 3'b001, 1'b0, 1'b1, 1'b0);
        tick();
        bus.ready_out_FPU = 1'b0;
        for (int i = 0; i < 7; i++) begin
            settle();
            tick();
        end
        settle(); chk("wd_before", {31'd0, bus.timeout_err}, 32'd0);
        tick();
        settle(); chk("wd_set", {31'd0, bus.timeout_err}, 32'd1);
        chk("wd_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        settle(); chk("wd_sticky", {31'd0, bus.timeout_err}, 32'd1);
        tick();
        bus.cnt_clr = 1'b1;
        settle();
        tick();
        bus.cnt_clr = 1'b0;
        settle();
        chk("wd_clr.err", {31'd0, bus.timeout_err}, 32'd0);
        chk("wd_clr.stall_cycles", 32'(bus.stall_cycles), 32'd0);
        chk("wd_clr.busy", {31'd0, bus.busy}, 32'd1);

        // Async reset mid-BUSY takes effect without a clock edge
        #1;
        reset = 1'b1;
        clear_inputs();
        #1;
        chk_out("async_rst", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("async_rst.err", {31'd0, bus.timeout_err}, 32'd0);
        chk("async_rst.stall_cycles", 32'(bus.stall_cycles), 32'd0);
        tick();
        reset = 1'b0;

        // Stall counter saturation and clear priority
        bus.valid_in = 1'b1; bus.wb_src_ID = SEL_DIV;
        for (int i = 0; i < 70; i++) tick();
        settle(); chk("stall_sat", 32'(bus.stall_cycles), 32'd63);
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        settle(); chk("clr_priority", 32'(bus.stall_cycles), 32'd0);
        tick();
        settle(); chk("after_clr", 32'(bus.stall_cycles), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
